// File: rtl/keypad_pkg.sv
// Shared constants, debounce state encoding and the row priority encoder
// used by the keypad scanner and its debounce sub-module.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 8;
    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAND  = 2'd1,
        PRESS = 2'd2,
        REL   = 2'd3
    } deb_state_t;

    // Lowest-numbered active row wins when several keys in a column are closed.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] low);
        logic [1:0] idx;
        if (low[0])      idx = 2'd0;
        else if (low[1]) idx = 2'd1;
        else if (low[2]) idx = 2'd2;
        else             idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: accepts a key after DEBOUNCE_SCANS identical scans and
// requires DEBOUNCE_SCANS empty scans before the next press can start.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done,
    input  logic       hit,
    input  logic [3:0] idx,
    output logic       push,
    output logic [3:0] push_idx
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    deb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]       cand_idx, cand_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cand_idx <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            cand_idx <= cand_next;
        end
    end

    assign cnt_inc  = cnt + CNT_W'(1);
    // A push only ever happens on a hit matching the candidate, so the live idx is the key.
    assign push_idx = idx;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand_idx;
        push       = 1'b0;
        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        cand_next = idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            push       = 1'b1;
                            state_next = PRESS;
                            cnt_next   = '0;
                        end else begin
                            state_next = CAND;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                CAND: begin
                    if (!hit) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (idx != cand_idx) begin
                        cand_next = idx;
                        cnt_next  = CNT_W'(1);
                    end else if (cnt_inc == CNT_MAX) begin
                        push       = 1'b1;
                        state_next = PRESS;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                PRESS: begin
                    if (!hit) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            state_next = REL;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                REL: begin
                    if (hit) begin
                        state_next = PRESS;
                        cnt_next   = '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column sequencer, row synchronizer, scan reduction
// and a one-entry holding register with present/ack/overrun handshake.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_COLS-1:0] col,
    input  logic [NUM_ROWS-1:0] row,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_present,
    input  logic                key_read_ack,
    output logic                key_overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]    dwell;
    logic [1:0]          col_idx;
    logic [NUM_ROWS-1:0] row_meta, row_sync;
    logic                acc_hit, scan_done, scan_hit;
    logic [3:0]          acc_idx, scan_idx;
    logic                sample, col_hit, prev_hit, merged_hit;
    logic [NUM_ROWS-1:0] row_low;
    logic [3:0]          merged_idx;
    logic                push;
    logic [3:0]          push_idx;

    // Synchronizer idles at all-ones so nothing reads as pressed out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Columns are visited in index order, so the first hit in a scan is the lowest index.
    always_comb begin
        sample     = (dwell == DWELL_LAST);
        row_low    = ~row_sync;
        col_hit    = |row_low;
        prev_hit   = (col_idx != 2'd0) && acc_hit;
        merged_hit = prev_hit || col_hit;
        merged_idx = prev_hit ? acc_idx : {col_idx, lowest_low(row_low)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell     <= '0;
            col_idx   <= '0;
            col       <= COL_RESET;
            acc_hit   <= 1'b0;
            acc_idx   <= '0;
            scan_done <= 1'b0;
            scan_hit  <= 1'b0;
            scan_idx  <= '0;
        end else begin
            scan_done <= sample && (col_idx == 2'd3);
            if (sample) begin
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
                col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
                acc_hit <= merged_hit;
                acc_idx <= merged_idx;
                if (col_idx == 2'd3) begin
                    scan_hit <= merged_hit;
                    scan_idx <= merged_idx;
                end
            end else begin
                dwell <= dwell + DIV_W'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .scan_done(scan_done),
        .hit      (scan_hit),
        .idx      (scan_idx),
        .push     (push),
        .push_idx (push_idx)
    );

    // A push coinciding with an ack replaces the unread key instead of overrunning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code    <= '0;
            key_present <= 1'b0;
            key_overrun <= 1'b0;
        end else if (push) begin
            if (!key_present || key_read_ack) begin
                key_code    <= {{(KEY_W-4){1'b0}}, push_idx};
                key_present <= 1'b1;
            end else begin
                key_overrun <= 1'b1;
            end
        end else if (key_read_ack && key_present) begin
            key_present <= 1'b0;
            key_overrun <= 1'b0;
        end
    end

endmodule
